bip_core_v2: RTL and testbench

BIP_CORE_V2 -- requirements
Module: bip_core_v2

---
 rtl/bip_pkg.sv | 50 +++++
 rtl/bip_decoder.sv | 69 ++++++
 rtl/bip_core_v2.sv | 152 +++++++++++++++
 tb/tb_bip_core_v2.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bip_pkg.sv
// Shared definitions for the BIP accumulator core: opcode map, FSM state
// encoding, decoder select encodings and the clogb2 width helper.
// Optional feature macro used by the core/decoder: BIP_BRANCH_EN.
package bip_pkg;

    localparam int NB_OPCODE_DEF = 5;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;
    localparam logic [4:0] OP_BEQ  = 5'b01000;
    localparam logic [4:0] OP_BNE  = 5'b01001;
    localparam logic [4:0] OP_JMP  = 5'b01010;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // ACC source select
    localparam logic [1:0] SELA_MEM = 2'd0;
    localparam logic [1:0] SELA_IMM = 2'd1;
    localparam logic [1:0] SELA_ALU = 2'd2;

    // Branch type
    localparam logic [1:0] BR_NONE = 2'd0;
    localparam logic [1:0] BR_EQ   = 2'd1;
    localparam logic [1:0] BR_NE   = 2'd2;
    localparam logic [1:0] BR_JMP  = 2'd3;

    // Number of bits needed to represent 'value' (value >= 1).
    function automatic int clogb2(input int value);
        int v;
        int n;
        v = value;
        n = 0;
        while (v > 0) begin
            n = n + 1;
            v = v >> 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode decoder for the BIP core. Unknown opcodes decode as
// NOP (no ACC write, no memory access, no branch). Branch opcodes only
// decode when BIP_BRANCH_EN is defined; otherwise they fall into NOP.
module bip_decoder
    import bip_pkg::*;
#(
    parameter int NB_OPCODE = NB_OPCODE_DEF
) (
    input  logic [NB_OPCODE-1:0] opcode_i,
    output logic [1:0]           sel_a_o,
    output logic                 sel_b_o,
    output logic                 wr_acc_o,
    output logic                 sub_o,
    output logic                 rd_o,
    output logic                 wr_o,
    output logic [1:0]           br_o,
    output logic                 hlt_o
);

    // Map opcode to datapath controls; defaults describe a NOP
    always_comb begin
        sel_a_o  = SELA_ALU;
        sel_b_o  = 1'b0;
        wr_acc_o = 1'b0;
        sub_o    = 1'b0;
        rd_o     = 1'b0;
        wr_o     = 1'b0;
        br_o     = BR_NONE;
        hlt_o    = 1'b0;
        case (opcode_i)
            NB_OPCODE'(OP_HLT):  hlt_o = 1'b1;
            NB_OPCODE'(OP_STO):  wr_o  = 1'b1;
            NB_OPCODE'(OP_LD): begin
                rd_o     = 1'b1;
                wr_acc_o = 1'b1;
                sel_a_o  = SELA_MEM;
            end
            NB_OPCODE'(OP_LDI): begin
                wr_acc_o = 1'b1;
                sel_a_o  = SELA_IMM;
            end
            NB_OPCODE'(OP_ADD): begin
                rd_o     = 1'b1;
                wr_acc_o = 1'b1;
            end
            NB_OPCODE'(OP_ADDI): begin
                wr_acc_o = 1'b1;
                sel_b_o  = 1'b1;
            end
            NB_OPCODE'(OP_SUB): begin
                rd_o     = 1'b1;
                wr_acc_o = 1'b1;
                sub_o    = 1'b1;
            end
            NB_OPCODE'(OP_SUBI): begin
                wr_acc_o = 1'b1;
                sel_b_o  = 1'b1;
                sub_o    = 1'b1;
            end
`ifdef BIP_BRANCH_EN
            NB_OPCODE'(OP_BEQ):  br_o = BR_EQ;
            NB_OPCODE'(OP_BNE):  br_o = BR_NE;
            NB_OPCODE'(OP_JMP):  br_o = BR_JMP;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/bip_core_v2.sv
// BIP accumulator core: PC, ACC and RUN/WAIT/HALT control. Memory
// instructions stall in WAIT until i_mem_ready; the instruction is latched
// on WAIT entry so o_rd/o_wr/o_addr_data stay stable while stalled.
// Optional feature macro: BIP_BRANCH_EN (enables BEQ/BNE/JMP).
module bip_core_v2
    import bip_pkg::*;
#(
    parameter int NB_BITS        = 16,
    parameter int INS_MEM_DEPTH  = 2048,
    parameter int DATA_MEM_DEPTH = 1024,
    parameter int NB_OPCODE      = NB_OPCODE_DEF,
    localparam int NB_PC   = clogb2(INS_MEM_DEPTH - 1),
    localparam int NB_DA   = clogb2(DATA_MEM_DEPTH - 1),
    localparam int NB_SIGX = NB_BITS - NB_OPCODE
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_BITS-1:0] i_instruction,
    input  logic [NB_BITS-1:0] i_data_mem,
    input  logic               i_mem_ready,
    output logic [NB_PC-1:0]   o_addr_ins,
    output logic [NB_DA-1:0]   o_addr_data,
    output logic [NB_BITS-1:0] o_data,
    output logic               o_rd,
    output logic               o_wr,
    output logic               o_halted
);

    state_e             state_q, state_d;
    logic [NB_PC-1:0]   pc_q, pc_d, pc_inc;
    logic [NB_BITS-1:0] acc_q, acc_d;
    logic [NB_BITS-1:0] ir_q, ir_d;

    logic [NB_BITS-1:0] cur_ins;
    logic [NB_SIGX-1:0] operand;
    logic [NB_BITS-1:0] imm, alu_b, alu_res, acc_new;
    logic               active, mem_op, br_take;

    logic [1:0] dec_sel_a, dec_br;
    logic       dec_sel_b, dec_wr_acc, dec_sub, dec_rd, dec_wr, dec_hlt;

    // While stalled, execute from the latched copy of the instruction
    assign cur_ins = (state_q == ST_WAIT) ? ir_q : i_instruction;
    assign operand = cur_ins[NB_SIGX-1:0];
    assign imm     = {{NB_OPCODE{operand[NB_SIGX-1]}}, operand};

    bip_decoder #(.NB_OPCODE(NB_OPCODE)) u_dec (
        .opcode_i (cur_ins[NB_BITS-1 -: NB_OPCODE]),
        .sel_a_o  (dec_sel_a),
        .sel_b_o  (dec_sel_b),
        .wr_acc_o (dec_wr_acc),
        .sub_o    (dec_sub),
        .rd_o     (dec_rd),
        .wr_o     (dec_wr),
        .br_o     (dec_br),
        .hlt_o    (dec_hlt)
    );

    assign alu_b   = dec_sel_b ? imm : i_data_mem;
    assign alu_res = dec_sub ? (acc_q - alu_b) : (acc_q + alu_b);
    assign mem_op  = dec_rd | dec_wr;
    assign pc_inc  = (pc_q == NB_PC'(INS_MEM_DEPTH - 1)) ? '0 : pc_q + NB_PC'(1);

    // Select the value written into ACC
    always_comb begin
        acc_new = alu_res;
        case (dec_sel_a)
            SELA_MEM: acc_new = i_data_mem;
            SELA_IMM: acc_new = imm;
            default:  acc_new = alu_res;
        endcase
    end

`ifdef BIP_BRANCH_EN
    logic acc_zero;
    assign acc_zero = (acc_q == '0);

    // Resolve branch decision from branch type and ACC zero test
    always_comb begin
        br_take = 1'b0;
        case (dec_br)
            BR_EQ:   br_take = acc_zero;
            BR_NE:   br_take = ~acc_zero;
            BR_JMP:  br_take = 1'b1;
            default: br_take = 1'b0;
        endcase
    end
`else
    logic unused_br;
    assign unused_br = ^dec_br;
    assign br_take   = 1'b0;
`endif

    // Next-state logic for FSM, PC, ACC and the stall instruction latch
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_RUN: begin
                if (dec_hlt) begin
                    state_d = ST_HALT;
                end else if (mem_op) begin
                    if (i_mem_ready) begin
                        if (dec_wr_acc) acc_d = acc_new;
                        pc_d = pc_inc;
                    end else begin
                        state_d = ST_WAIT;
                        ir_d    = i_instruction;
                    end
                end else begin
                    if (dec_wr_acc) acc_d = acc_new;
                    pc_d = br_take ? operand[NB_PC-1:0] : pc_inc;
                end
            end
            ST_WAIT: begin
                if (i_mem_ready) begin
                    if (dec_wr_acc) acc_d = acc_new;
                    pc_d    = pc_inc;
                    state_d = ST_RUN;
                end
            end
            default: ;
        endcase
    end

    // State registers, cleared asynchronously by reset
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            acc_q   <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            ir_q    <= ir_d;
        end
    end

    // Requests are gated by reset so they drop without waiting for an edge
    assign active      = i_rst & (state_q != ST_HALT);
    assign o_rd        = active & dec_rd;
    assign o_wr        = active & dec_wr;
    assign o_addr_ins  = pc_q;
    assign o_addr_data = cur_ins[NB_DA-1:0];
    assign o_data      = acc_q;
    assign o_halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_bip_core_v2.sv
// Self-checking bench for bip_core_v2: table-driven single-cycle vectors
// with a scoreboard queue, plus hand-written stall, reset and wrap sequences.
module tb_bip_core_v2;

`ifdef BIP_BRANCH_EN
    localparam bit BR = 1'b1;
`else
    localparam bit BR = 1'b0;
`endif

    localparam logic [4:0] HLT = 5'b00000, STO = 5'b00001, LD = 5'b00010,
                           LDI = 5'b00011, ADDI = 5'b00101, SUBI = 5'b00111,
                           ADD = 5'b00100, SUB = 5'b00110, BEQ = 5'b01000,
                           BNE = 5'b01001, JMP = 5'b01010, NOP = 5'b11111;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [15:0] i_instruction = '0;
    logic [15:0] i_data_mem = '0;
    logic        i_mem_ready = 1'b0;
    logic [10:0] o_addr_ins;
    logic [9:0]  o_addr_data;
    logic [15:0] o_data;
    logic        o_rd, o_wr, o_halted;

    always #5 i_clk = ~i_clk;

    bip_core_v2 dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_instruction(i_instruction),
        .i_data_mem   (i_data_mem),
        .i_mem_ready  (i_mem_ready),
        .o_addr_ins   (o_addr_ins),
        .o_addr_data  (o_addr_data),
        .o_data       (o_data),
        .o_rd         (o_rd),
        .o_wr         (o_wr),
        .o_halted     (o_halted)
    );

    typedef struct {
        logic        rst;
        logic [15:0] ins;
        logic        rdy;
        logic [15:0] dm;
        logic        exp_rd;
        logic        exp_wr;
        logic [10:0] exp_pc;
        logic [15:0] exp_acc;
        logic        exp_halt;
    } vec_t;

    typedef struct {
        logic [10:0] pc;
        logic [15:0] acc;
        logic        halt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ins(input logic [4:0] op, input logic [10:0] opr);
        return {op, opr};
    endfunction

    function automatic vec_t mk(input logic r, input logic [15:0] in, input logic rdy,
                                input logic [15:0] dm, input logic erd, input logic ewr,
                                input logic [10:0] epc, input logic [15:0] eacc,
                                input logic eh);
        vec_t v;
        v.rst = r; v.ins = in; v.rdy = rdy; v.dm = dm; v.exp_rd = erd; v.exp_wr = ewr;
        v.exp_pc = epc; v.exp_acc = eacc; v.exp_halt = eh;
        return v;
    endfunction

    // Assert reset across one negedge with a memory op presented; outputs
    // must be idle regardless. Returns just after a negedge with reset released.
    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b0;
        i_instruction = ins(LD, 11'd9);
        i_mem_ready = 1'b0;
        #1;
        check("rst_pc", o_addr_ins, 0);
        check("rst_acc", o_data, 0);
        check("rst_rd", o_rd, 0);
        check("rst_wr", o_wr, 0);
        check("rst_halt", o_halted, 0);
        @(negedge i_clk);
        i_rst = 1'b1;
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        if (v.rst) do_reset();
        else @(negedge i_clk);
        i_instruction = v.ins;
        i_mem_ready   = v.rdy;
        i_data_mem    = v.dm;
        #1;
        check($sformatf("v%0d_rd", idx), o_rd, v.exp_rd);
        check($sformatf("v%0d_wr", idx), o_wr, v.exp_wr);
        check($sformatf("v%0d_addr", idx), o_addr_data, v.ins[9:0]);
        e.pc = v.exp_pc; e.acc = v.exp_acc; e.halt = v.exp_halt;
        sb.push_back(e);
        @(posedge i_clk);
        #1;
        e = sb.pop_front();
        check($sformatf("v%0d_pc", idx), o_addr_ins, e.pc);
        check($sformatf("v%0d_acc", idx), o_data, e.acc);
        check($sformatf("v%0d_halt", idx), o_halted, e.halt);
    endtask

    initial begin
        // Immediate arithmetic then halt; core must freeze afterwards
        tbl.push_back(mk(1, ins(LDI, 11'd5),     1, 16'h0, 0, 0, 11'd1, 16'h0005, 0));
        tbl.push_back(mk(0, ins(ADDI, 11'h7FD),  1, 16'h0, 0, 0, 11'd2, 16'h0002, 0));
        tbl.push_back(mk(0, ins(SUBI, 11'd4),    1, 16'h0, 0, 0, 11'd3, 16'hFFFE, 0));
        tbl.push_back(mk(0, ins(HLT, 11'd0),     1, 16'h0, 0, 0, 11'd3, 16'hFFFE, 1));
        tbl.push_back(mk(0, ins(LD, 11'd9),      1, 16'h55, 0, 0, 11'd3, 16'hFFFE, 1));
        tbl.push_back(mk(0, ins(STO, 11'd4),     1, 16'h0, 0, 0, 11'd3, 16'hFFFE, 1));
        // Memory ops with ready, wrap-around, sign extension, NOP, branches
        tbl.push_back(mk(1, ins(LDI, 11'h3FF),   1, 16'h0, 0, 0, 11'd1, 16'h03FF, 0));
        tbl.push_back(mk(0, ins(ADD, 11'd3),     1, 16'hFC01, 1, 0, 11'd2, 16'h0000, 0));
        tbl.push_back(mk(0, ins(SUB, 11'd4),     1, 16'h0001, 1, 0, 11'd3, 16'hFFFF, 0));
        tbl.push_back(mk(0, ins(LDI, 11'h400),   1, 16'h0, 0, 0, 11'd4, 16'hFC00, 0));
        tbl.push_back(mk(0, ins(NOP, 11'h123),   1, 16'h0, 0, 0, 11'd5, 16'hFC00, 0));
        tbl.push_back(mk(0, ins(STO, 11'd5),     1, 16'h0, 0, 1, 11'd6, 16'hFC00, 0));
        tbl.push_back(mk(0, ins(LDI, 11'd0),     1, 16'h0, 0, 0, 11'd7, 16'h0000, 0));
        tbl.push_back(mk(0, ins(BEQ, 11'd20),    1, 16'h0, 0, 0, BR ? 11'd20 : 11'd8, 16'h0000, 0));
        tbl.push_back(mk(0, ins(LDI, 11'd1),     1, 16'h0, 0, 0, BR ? 11'd21 : 11'd9, 16'h0001, 0));
        tbl.push_back(mk(0, ins(BEQ, 11'd20),    1, 16'h0, 0, 0, BR ? 11'd22 : 11'd10, 16'h0001, 0));
        tbl.push_back(mk(0, ins(BNE, 11'd30),    1, 16'h0, 0, 0, BR ? 11'd30 : 11'd11, 16'h0001, 0));
        tbl.push_back(mk(0, ins(JMP, 11'h7FF),   1, 16'h0, 0, 0, BR ? 11'd2047 : 11'd12, 16'h0001, 0));
        tbl.push_back(mk(0, ins(5'b01011, 11'd0), 1, 16'h0, 0, 0, BR ? 11'd0 : 11'd13, 16'h0001, 0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // STO stalled three cycles: request held, PC advances once
        do_reset();
        i_instruction = ins(LD, 11'd0); i_mem_ready = 1'b1; i_data_mem = 16'h1234;
        @(posedge i_clk); #1;
        check("sto_pre_acc", o_data, 16'h1234);
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk);
            i_instruction = ins(STO, 11'd7);
            i_data_mem    = 16'h0;
            i_mem_ready   = (c == 3);
            #1;
            check($sformatf("sto_wr_c%0d", c), o_wr, 1);
            check($sformatf("sto_rd_c%0d", c), o_rd, 0);
            check($sformatf("sto_addr_c%0d", c), o_addr_data, 7);
            check($sformatf("sto_data_c%0d", c), o_data, 16'h1234);
            @(posedge i_clk); #1;
            check($sformatf("sto_pc_c%0d", c), o_addr_ins, (c == 3) ? 2 : 1);
        end
        @(negedge i_clk);
        i_instruction = ins(NOP, 11'd0); i_mem_ready = 1'b0;
        #1;
        check("sto_wr_after", o_wr, 0);

        // LD stalled two cycles; ACC loads on the ready edge
        @(posedge i_clk); #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            i_instruction = ins(LD, 11'd9);
            i_data_mem    = (c == 2) ? 16'hBEEF : 16'h0000;
            i_mem_ready   = (c == 2);
            #1;
            check($sformatf("ld_rd_c%0d", c), o_rd, 1);
            check($sformatf("ld_addr_c%0d", c), o_addr_data, 9);
            @(posedge i_clk); #1;
            check($sformatf("ld_acc_c%0d", c), o_data, (c == 2) ? 16'hBEEF : 16'h1234);
            check($sformatf("ld_pc_c%0d", c), o_addr_ins, (c == 2) ? 4 : 3);
        end
        @(negedge i_clk);
        i_instruction = ins(NOP, 11'd0); i_mem_ready = 1'b0;
        #1;
        check("ld_rd_after", o_rd, 0);

        // Reset asserted mid-WAIT drops the request without a clock edge
        @(negedge i_clk);
        i_instruction = ins(LD, 11'd9); i_mem_ready = 1'b0;
        @(posedge i_clk); #2;
        check("wrst_rd_pre", o_rd, 1);
        i_rst = 1'b0;
        #1;
        check("wrst_rd", o_rd, 0);
        check("wrst_wr", o_wr, 0);
        check("wrst_pc", o_addr_ins, 0);
        check("wrst_acc", o_data, 0);
        @(negedge i_clk);
        i_rst = 1'b1;
        i_instruction = ins(LDI, 11'd5);
        #1;
        check("wrst_fetch0", o_addr_ins, 0);
        @(posedge i_clk); #1;
        check("wrst_pc1", o_addr_ins, 1);
        check("wrst_acc5", o_data, 5);

        // Straight-line NOPs wrap PC from 2047 to 0
        do_reset();
        i_instruction = ins(NOP, 11'd0);
        for (int c = 0; c < 2047; c++) @(posedge i_clk);
        #1;
        check("wrap_top", o_addr_ins, 2047);
        @(posedge i_clk); #1;
        check("wrap_zero", o_addr_ins, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
